pa_fifo_ext: RTL and testbench

PA_FIFO_EXT -- requirements
Module: pa_fifo_ext

---
 rtl/pa_fifo_ext.sv | 94 +++++++++
 tb/tb_pa_fifo_ext.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pa_fifo_ext.sv
// rtl/pa_fifo_ext.sv - single-clock FIFO with registered or first-word-fall-through read,
// occupancy thresholds, flush and sticky overrun/underrun flags.
module pa_fifo_ext #(
   parameter int SIZE_DATA  = 8,
   parameter int SIZE_DEPTH = 16,
   parameter int FWFT_MODE  = 0,
   parameter int AF_LEVEL   = SIZE_DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_wr_en,
   input  logic                        i_rd_en,
   input  logic                        i_flush,
   input  logic                        i_clr_err,
   input  logic [SIZE_DATA-1:0]        i_data,
   output logic [SIZE_DATA-1:0]        o_data,
   output logic                        o_fifo_full,
   output logic                        o_fifo_empty,
   output logic                        o_almost_full,
   output logic                        o_almost_empty,
   output logic [$clog2(SIZE_DEPTH):0] o_level,
   output logic                        o_overrun,
   output logic                        o_underrun
);

   localparam int AW = $clog2(SIZE_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW-1:0] AF_L    = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_L    = PW'(AE_LEVEL);

   logic [SIZE_DATA-1:0] mem [SIZE_DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [SIZE_DATA-1:0] data_q;
   logic [SIZE_DATA-1:0] head;
   logic                 wr_acc;
   logic                 rd_acc;

   // Pointer MSB is the wrap bit: same index with differing wrap means full.
   assign o_fifo_empty   = (wr_ptr == rd_ptr);
   assign o_fifo_full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign o_level        = wr_ptr - rd_ptr;
   assign o_almost_full  = (o_level >= AF_L);
   assign o_almost_empty = (o_level <= AE_L);

   assign head   = mem[rd_ptr[AW-1:0]];
   assign wr_acc = i_wr_en && !o_fifo_full && !i_flush;
   assign rd_acc = i_rd_en && !o_fifo_empty && !i_flush;

   // In FWFT mode data_q only holds the word shown while the FIFO is empty.
   assign o_data = ((FWFT_MODE != 0) && !o_fifo_empty) ? head : data_q;

   always_ff @(posedge i_clk) begin
      if (wr_acc) begin
         mem[wr_ptr[AW-1:0]] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         data_q <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         if (FWFT_MODE != 0) begin
            data_q <= o_data;
         end
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            data_q <= head;
         end
      end
   end

   // A fresh error in the clearing cycle keeps its flag set.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_overrun  <= 1'b0;
         o_underrun <= 1'b0;
      end else begin
         o_overrun  <= (i_wr_en && o_fifo_full)  || (o_overrun  && !i_clr_err);
         o_underrun <= (i_rd_en && o_fifo_empty) || (o_underrun && !i_clr_err);
      end
   end

endmodule

// File: tb/tb_pa_fifo_ext.sv
// tb/tb_pa_fifo_ext.sv - self-checking bench for pa_fifo_ext, registered and FWFT instances
// driven in parallel against a queue model and a fill-sequence vector table.
module tb_pa_fifo_ext;

   logic       clk;
   logic       rst_n;
   logic       wr_en, rd_en, flush, clr_err;
   logic [7:0] din;

   logic [7:0] data0, data1;
   logic       full0, empty0, af0, ae0, ovr0, und0;
   logic       full1, empty1, af1, ae1, ovr1, und1;
   logic [3:0] lvl0, lvl1;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   logic [7:0] d0_exp;
   logic [7:0] fw_hold;
   logic       m_ovr, m_und;

   typedef struct {
      logic       wr;
      logic       rd;
      logic [7:0] d;
      logic [3:0] lvl;
      logic       af;
      logic       ae;
      logic       full;
      logic       ovr;
   } vec_t;

   vec_t tbl[9];

   pa_fifo_ext #(.SIZE_DATA(8), .SIZE_DEPTH(8), .FWFT_MODE(0), .AF_LEVEL(6), .AE_LEVEL(2)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_rd_en(rd_en), .i_flush(flush),
      .i_clr_err(clr_err), .i_data(din), .o_data(data0), .o_fifo_full(full0),
      .o_fifo_empty(empty0), .o_almost_full(af0), .o_almost_empty(ae0), .o_level(lvl0),
      .o_overrun(ovr0), .o_underrun(und0));

   pa_fifo_ext #(.SIZE_DATA(8), .SIZE_DEPTH(8), .FWFT_MODE(1), .AF_LEVEL(6), .AE_LEVEL(2)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_rd_en(rd_en), .i_flush(flush),
      .i_clr_err(clr_err), .i_data(din), .o_data(data1), .o_fifo_full(full1),
      .o_fifo_empty(empty1), .o_almost_full(af1), .o_almost_empty(ae1), .o_level(lvl1),
      .o_overrun(ovr1), .o_underrun(und1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      d0_exp  = 8'h00;
      fw_hold = 8'h00;
      m_ovr   = 1'b0;
      m_und   = 1'b0;
   endtask

   task automatic check_all(input string tag);
      int         n;
      logic [7:0] d1_exp;
      n = mq.size();
      d1_exp = (n != 0) ? mq[0] : fw_hold;
      chk({tag, " lvl0"},  64'(lvl0),   64'(n));
      chk({tag, " lvl1"},  64'(lvl1),   64'(n));
      chk({tag, " full0"}, 64'(full0),  64'(n == 8));
      chk({tag, " empty0"},64'(empty0), 64'(n == 0));
      chk({tag, " empty1"},64'(empty1), 64'(n == 0));
      chk({tag, " af0"},   64'(af0),    64'(n >= 6));
      chk({tag, " ae0"},   64'(ae0),    64'(n <= 2));
      chk({tag, " ovr0"},  64'(ovr0),   64'(m_ovr));
      chk({tag, " und0"},  64'(und0),   64'(m_und));
      chk({tag, " ovr1"},  64'(ovr1),   64'(m_ovr));
      chk({tag, " und1"},  64'(und1),   64'(m_und));
      chk({tag, " data0"}, 64'(data0),  64'(d0_exp));
      chk({tag, " data1"}, 64'(data1),  64'(d1_exp));
   endtask

   // Drive one cycle; the model decides acceptance from pre-edge occupancy.
   task automatic step(input string tag, input logic wr, input logic rd, input logic fl,
                       input logic clr, input logic [7:0] d);
      int         n;
      logic       wacc, racc;
      logic [7:0] popped;
      wr_en = wr; rd_en = rd; flush = fl; clr_err = clr; din = d;
      @(posedge clk);
      n    = mq.size();
      wacc = wr && (n != 8) && !fl;
      racc = rd && (n != 0) && !fl;
      m_ovr = (wr && (n == 8)) || (m_ovr && !clr);
      m_und = (rd && (n == 0)) || (m_und && !clr);
      if (fl) begin
         if (n != 0) fw_hold = mq[0];
         mq.delete();
      end
      if (racc) begin
         popped = mq.pop_front();
         exp_q.push_back(popped);
         fw_hold = popped;
      end
      if (wacc) mq.push_back(d);
      #1;
      if (exp_q.size() != 0) d0_exp = exp_q.pop_front();
      check_all(tag);
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 8'h01, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 8'h02, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 8'h03, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 8'h04, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 8'h05, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 8'h06, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 8'h07, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 8'h08, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8] = '{1'b1, 1'b0, 8'hFF, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1};

      rst_n = 1'b0; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; din = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      // Fill from empty, ninth write rejected with overrun.
      for (int i = 0; i < 9; i++) begin
         step("fill", tbl[i].wr, tbl[i].rd, 1'b0, 1'b0, tbl[i].d);
         chk("tbl lvl",  64'(lvl0),  64'(tbl[i].lvl));
         chk("tbl af",   64'(af0),   64'(tbl[i].af));
         chk("tbl ae",   64'(ae0),   64'(tbl[i].ae));
         chk("tbl full", 64'(full0), 64'(tbl[i].full));
         chk("tbl ovr",  64'(ovr0),  64'(tbl[i].ovr));
      end

      // Drain: registered data 0x01..0x08, ninth read underruns and data holds.
      for (int i = 0; i < 9; i++) step("drain", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("drain hold", 64'(data0), 64'h08);
      chk("drain und",  64'(und0),  64'h1);
      step("clr", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

      // FWFT single word fall-through then pop.
      step("fwft wr", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
      chk("fwft a5", 64'(data1), 64'hA5);
      step("fwft rd", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("fwft hold", 64'(data1), 64'hA5);

      // Wrap at constant level 4.
      for (int i = 0; i < 4; i++) step("pre", 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i));
      for (int i = 0; i < 20; i++) begin
         step("wrap", 1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
         chk("wrap lvl", 64'(lvl0), 64'd4);
      end
      chk("wrap noerr", 64'({ovr0, und0}), 64'h0);

      // Full plus simultaneous read/write: read only, overrun set, then clear.
      for (int i = 0; i < 4; i++) step("top", 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
      step("full rw", 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
      chk("full rw lvl", 64'(lvl0), 64'd7);
      chk("full rw ovr", 64'(ovr0), 64'h1);
      step("clr2", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

      // Clear with a concurrent new error keeps the flag.
      step("wr8", 1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
      step("clr+err", 1'b1, 1'b0, 1'b0, 1'b1, 8'h78);
      chk("clr+err ovr", 64'(ovr0), 64'h1);
      step("clr3", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

      // Flush at level 5 with concurrent write.
      for (int i = 0; i < 3; i++) step("to5", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("lvl5", 64'(lvl0), 64'd5);
      step("flush", 1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
      chk("flush lvl", 64'(lvl0), 64'd0);
      chk("flush empty", 64'(empty1), 64'h1);

      // Async reset mid-burst, with an error flag set beforehand.
      step("und", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) step("burst", 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h50 + i));
      wr_en = 1'b1; din = 8'h5F;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async rst");
      wr_en = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      step("post wr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
      step("post wr2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h3D);
      step("post rd", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("post first", 64'(data0), 64'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
